// File: rtl/btb_fetch_unit.sv
// rtl/btb_fetch_unit.sv - fetch-stage next-PC generator with direct-mapped BTB
//
// Owns the fetch PC and a direct-mapped branch target buffer indexed by
// pc[INDEX_BITS+1:2]. The BTB hit and target are combined with the predictor's
// taken bit to steer fetch. The prediction is latched into IF/ID. Resolved taken
// branches from EX write the BTB, and EX mispredictions redirect the PC.
//
// Optional macro BTB_BYPASS_EN: when defined, a same-cycle EX update to the
// entry being looked up is forwarded into the lookup.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   stall               hold PC and IF/ID prediction registers
//   load_IF_ID          IF/ID load enable
//   prediction          predictor taken bit for current pc
//   ex_update           EX resolved a taken branch: write BTB entry idx(ex_pc)
//   ex_pc, ex_target    PC and target of the resolved branch
//   ex_mispredict       redirect fetch to ex_correct_pc (overrides stall)
//   ex_correct_pc       redirect address
//   pc                  registered fetch PC
//   btb_hit, pred_taken combinational lookup results for pc
//   if_id_pred_taken    registered pred_taken
//   if_id_pred_target   registered predicted next PC
module btb_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0060,
  parameter int          INDEX_BITS = 4,
  parameter int          TAG_BITS   = 32 - INDEX_BITS - 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        load_IF_ID,
  input  logic        prediction,
  input  logic        ex_update,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_mispredict,
  input  logic [31:0] ex_correct_pc,
  output logic [31:0] pc,
  output logic        btb_hit,
  output logic        pred_taken,
  output logic        if_id_pred_taken,
  output logic [31:0] if_id_pred_target
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [31:0]           pc_q, pc_d;
  logic                  if_id_pred_taken_q, if_id_pred_taken_d;
  logic [31:0]           if_id_pred_target_q, if_id_pred_target_d;
  logic [ENTRIES-1:0]    valid_q, valid_d;
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [TAG_BITS-1:0]   tag_d    [ENTRIES];
  logic [31:0]           target_q [ENTRIES];
  logic [31:0]           target_d [ENTRIES];

  logic [INDEX_BITS-1:0] idx, ex_idx;
  logic [TAG_BITS-1:0]   pc_tag, ex_tag;
  logic                  lk_valid;
  logic [TAG_BITS-1:0]   lk_tag;
  logic [31:0]           lk_target;
  logic [31:0]           pc_plus4;
  logic                  hit;
  logic                  taken;

  assign idx      = pc_q[INDEX_BITS+1:2];
  assign pc_tag   = pc_q[31:INDEX_BITS+2];
  assign ex_idx   = ex_pc[INDEX_BITS+1:2];
  assign ex_tag   = ex_pc[31:INDEX_BITS+2];
  assign pc_plus4 = pc_q + 32'd4;

  // Lookup reads the stored entry; the write from EX lands on the clock edge,
  // so without forwarding a same-cycle update is seen one cycle later.
  always_comb begin
    lk_valid  = valid_q[idx];
    lk_tag    = tag_q[idx];
    lk_target = target_q[idx];
`ifdef BTB_BYPASS_EN
    if (ex_update && (ex_idx == idx)) begin
      lk_valid  = 1'b1;
      lk_tag    = ex_tag;
      lk_target = ex_target;
    end
`else
`endif
  end

  assign hit   = lk_valid && (lk_tag == pc_tag);
  assign taken = hit && prediction;

  // Redirect beats stall so a flush is never lost behind a stalled front end.
  always_comb begin
    pc_d = pc_plus4;
    if (ex_mispredict) begin
      pc_d = ex_correct_pc;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (taken) begin
      pc_d = lk_target;
    end
  end

  // The flush clears only the taken bit; the target field is meaningless
  // once taken is 0 and follows the normal load rule.
  always_comb begin
    if_id_pred_taken_d  = if_id_pred_taken_q;
    if_id_pred_target_d = if_id_pred_target_q;
    if (load_IF_ID && !stall) begin
      if_id_pred_taken_d  = taken;
      if_id_pred_target_d = taken ? lk_target : pc_plus4;
    end
    if (ex_mispredict) begin
      if_id_pred_taken_d = 1'b0;
    end
  end

  // Update is independent of stall; aliasing entries are simply replaced.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (ex_update) begin
      valid_d[ex_idx]  = 1'b1;
      tag_d[ex_idx]    = ex_tag;
      target_d[ex_idx] = ex_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q                <= RESET_PC;
      valid_q             <= '0;
      if_id_pred_taken_q  <= 1'b0;
      if_id_pred_target_q <= RESET_PC + 32'd4;
    end else begin
      pc_q                <= pc_d;
      valid_q             <= valid_d;
      if_id_pred_taken_q  <= if_id_pred_taken_d;
      if_id_pred_target_q <= if_id_pred_target_d;
    end
  end

  // Tag and target storage carries no reset; valid bits gate its use.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign pc                = pc_q;
  assign btb_hit           = hit;
  assign pred_taken        = taken;
  assign if_id_pred_taken  = if_id_pred_taken_q;
  assign if_id_pred_target = if_id_pred_target_q;

endmodule

// File: tb/tb_btb_fetch_unit.sv
// tb/tb_btb_fetch_unit.sv - directed self-checking bench for btb_fetch_unit
module tb_btb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        load_IF_ID;
  logic        prediction;
  logic        ex_update;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_mispredict;
  logic [31:0] ex_correct_pc;
  logic [31:0] pc;
  logic        btb_hit;
  logic        pred_taken;
  logic        if_id_pred_taken;
  logic [31:0] if_id_pred_target;

  int n_vec = 0;
  int n_err = 0;

  btb_fetch_unit dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .load_IF_ID        (load_IF_ID),
    .prediction        (prediction),
    .ex_update         (ex_update),
    .ex_pc             (ex_pc),
    .ex_target         (ex_target),
    .ex_mispredict     (ex_mispredict),
    .ex_correct_pc     (ex_correct_pc),
    .pc                (pc),
    .btb_hit           (btb_hit),
    .pred_taken        (pred_taken),
    .if_id_pred_taken  (if_id_pred_taken),
    .if_id_pred_target (if_id_pred_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] addr);
    ex_mispredict = 1'b1;
    ex_correct_pc = addr;
    tick();
    ex_mispredict = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; load_IF_ID = 1'b1; prediction = 1'b0;
    ex_update = 1'b0; ex_pc = '0; ex_target = '0;
    ex_mispredict = 1'b0; ex_correct_pc = '0;
    #2;
    check("rst_pc", pc, 32'h60);
    check("rst_hit", {31'd0, btb_hit}, 32'd0);
    check("rst_ifid_taken", {31'd0, if_id_pred_taken}, 32'd0);
    check("rst_ifid_target", if_id_pred_target, 32'h64);
    @(posedge clk); #1 rst = 1'b0;

    // sequential fetch after reset
    check("seq_pc0", pc, 32'h60);
    check("seq_hit0", {31'd0, btb_hit}, 32'd0);
    tick(); check("seq_pc1", pc, 32'h64);
    check("seq_hit1", {31'd0, btb_hit}, 32'd0);
    tick(); check("seq_pc2", pc, 32'h68);
    tick(); check("seq_pc3", pc, 32'h6C);
    check("seq_hit3", {31'd0, btb_hit}, 32'd0);

    // update 0x64 -> 0x200 and redirect to 0x60 in the same cycle
    ex_update = 1'b1; ex_pc = 32'h64; ex_target = 32'h200;
    redirect(32'h60);
    ex_update = 1'b0;
    check("upd_redirect_pc", pc, 32'h60);
    check("upd_redirect_flush", {31'd0, if_id_pred_taken}, 32'd0);

    // taken hit at 0x64
    prediction = 1'b1; #1;
    check("miss_at_60", {31'd0, btb_hit}, 32'd0);
    tick(); check("pc_64", pc, 32'h64);
    check("hit_64", {31'd0, btb_hit}, 32'd1);
    check("pt_64", {31'd0, pred_taken}, 32'd1);
    tick(); check("taken_pc", pc, 32'h200);
    check("taken_ifid", {31'd0, if_id_pred_taken}, 32'd1);
    check("taken_ifid_tgt", if_id_pred_target, 32'h200);

    // hit with prediction = 0 falls through
    prediction = 1'b0;
    redirect(32'h64);
    check("flush_ifid", {31'd0, if_id_pred_taken}, 32'd0);
    check("nt_hit", {31'd0, btb_hit}, 32'd1);
    check("nt_pt", {31'd0, pred_taken}, 32'd0);
    tick(); check("nt_pc", pc, 32'h68);
    check("nt_ifid", {31'd0, if_id_pred_taken}, 32'd0);
    check("nt_ifid_tgt", if_id_pred_target, 32'h68);

    // alias: same index, different tag
    prediction = 1'b1;
    redirect(32'hA4);
    check("alias_pc", pc, 32'hA4);
    check("alias_hit", {31'd0, btb_hit}, 32'd0);
    tick(); check("alias_next", pc, 32'hA8);

    // stall + mispredict: redirect wins and flushes
    redirect(32'h64);
    tick(); check("pre_stall_pc", pc, 32'h200);
    check("pre_stall_ifid", {31'd0, if_id_pred_taken}, 32'd1);
    stall = 1'b1;
    redirect(32'h300);
    check("stall_redirect_pc", pc, 32'h300);
    check("stall_redirect_flush", {31'd0, if_id_pred_taken}, 32'd0);
    check("stall_ifid_tgt_hold", if_id_pred_target, 32'h200);
    for (int i = 0; i < 3; i++) begin
      tick(); check("stall_hold", pc, 32'h300);
    end
    stall = 1'b0;

    // wrap at top of address space
    redirect(32'hFFFF_FFFC);
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_hit", {31'd0, btb_hit}, 32'd0);
    tick(); check("wrap_next", pc, 32'h0);

    // same-cycle update and lookup at 0x68
    redirect(32'h68);
    ex_update = 1'b1; ex_pc = 32'h68; ex_target = 32'h400; #1;
`ifdef BTB_BYPASS_EN
    check("byp_hit", {31'd0, btb_hit}, 32'd1);
    tick(); ex_update = 1'b0;
    check("byp_next", pc, 32'h400);
`else
    check("byp_hit", {31'd0, btb_hit}, 32'd0);
    tick(); ex_update = 1'b0;
    check("byp_next", pc, 32'h6C);
`endif
    redirect(32'h68);
    check("later_hit_68", {31'd0, btb_hit}, 32'd1);
    tick(); check("later_pc", pc, 32'h400);
    check("later_ifid", {31'd0, if_id_pred_taken}, 32'd1);

    // asynchronous reset mid-cycle
    #2 rst = 1'b1; #1;
    check("async_rst_pc", pc, 32'h60);
    check("async_rst_ifid", {31'd0, if_id_pred_taken}, 32'd0);
    check("async_rst_tgt", if_id_pred_target, 32'h64);
    @(posedge clk); #1 rst = 1'b0;
    redirect(32'h64);
    check("post_rst_miss_64", {31'd0, btb_hit}, 32'd0);
    redirect(32'h68);
    check("post_rst_miss_68", {31'd0, btb_hit}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
